// File: rtl/ahb_lite_manager.sv
// AHB-Lite manager: converts a valid/ready request stream into pipelined single
// transfers, with two-cycle ERROR handling that cancels and reissues the pending address.
module ahb_lite_manager #(
    parameter int unsigned PA_BITS = 34,
    parameter int unsigned AHBW    = 64
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic [PA_BITS-1:0]    ReqAddr,
    input  logic                  ReqWrite,
    input  logic [2:0]            ReqSize,
    input  logic [AHBW-1:0]       ReqWData,
    input  logic [(AHBW/8)-1:0]   ReqStrb,
    output logic                  RspValid,
    output logic [AHBW-1:0]       RspData,
    output logic                  RspErr,
    output logic [PA_BITS-1:0]    HADDR,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [1:0]            HTRANS,
    output logic                  HMASTLOCK,
    output logic [AHBW-1:0]       HWDATA,
    output logic [(AHBW/8)-1:0]   HWSTRB,
    input  logic [AHBW-1:0]       HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    localparam int unsigned STRB_W        = AHBW / 8;
    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;

    // Address-phase register
    logic                avld_q, avld_d;
    logic [PA_BITS-1:0]  a_addr_q, a_addr_d;
    logic                a_write_q, a_write_d;
    logic [2:0]          a_size_q, a_size_d;
    logic [AHBW-1:0]     a_wdata_q, a_wdata_d;
    logic [STRB_W-1:0]   a_strb_q, a_strb_d;
    // Data-phase register
    logic                dvld_q, dvld_d;
    logic                d_write_q, d_write_d;
    logic [AHBW-1:0]     d_wdata_q, d_wdata_d;
    logic [STRB_W-1:0]   d_strb_q, d_strb_d;
    // Error cancel, bus transfer type and response
    logic                err_cancel_q, err_cancel_d;
    logic [1:0]          htrans_q, htrans_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [AHBW-1:0]     rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;

    logic req_ready;
    logic a_done;
    logic d_done;

    assign req_ready = ~avld_q | (HREADY & ~err_cancel_q);
    assign a_done    = avld_q & ~err_cancel_q & HREADY;
    assign d_done    = dvld_q & HREADY;

    // Next-state logic for both pipeline stages, error cancel and response
    always_comb begin
        avld_d       = avld_q;
        a_addr_d     = a_addr_q;
        a_write_d    = a_write_q;
        a_size_d     = a_size_q;
        a_wdata_d    = a_wdata_q;
        a_strb_d     = a_strb_q;
        dvld_d       = dvld_q;
        d_write_d    = d_write_q;
        d_wdata_d    = d_wdata_q;
        d_strb_d     = d_strb_q;
        err_cancel_d = err_cancel_q;
        rsp_valid_d  = d_done;
        rsp_data_d   = '0;
        rsp_err_d    = d_done & HRESP;

        if (ReqValid && req_ready) begin
            avld_d    = 1'b1;
            a_addr_d  = ReqAddr;
            a_write_d = ReqWrite;
            a_size_d  = ReqSize;
            a_wdata_d = ReqWData;
            a_strb_d  = ReqStrb;
        end else if (req_ready) begin
            avld_d = 1'b0;
        end

        if (a_done) begin
            dvld_d    = 1'b1;
            d_write_d = a_write_q;
            d_wdata_d = a_wdata_q;
            d_strb_d  = a_strb_q;
        end else if (HREADY) begin
            dvld_d = 1'b0;
        end

        // First ERROR cycle cancels the pending address; the ready edge ends it
        if (err_cancel_q && HREADY) begin
            err_cancel_d = 1'b0;
        end else if (dvld_q && HRESP && !HREADY) begin
            err_cancel_d = 1'b1;
        end

        if (d_done && !d_write_q) begin
            rsp_data_d = HRDATA;
        end

        htrans_d = (avld_d && !err_cancel_d) ? HTRANS_NONSEQ : HTRANS_IDLE;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            avld_q       <= 1'b0;
            a_addr_q     <= '0;
            a_write_q    <= 1'b0;
            a_size_q     <= 3'b000;
            a_wdata_q    <= '0;
            a_strb_q     <= '0;
            dvld_q       <= 1'b0;
            d_write_q    <= 1'b0;
            d_wdata_q    <= '0;
            d_strb_q     <= '0;
            err_cancel_q <= 1'b0;
            htrans_q     <= HTRANS_IDLE;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            avld_q       <= avld_d;
            a_addr_q     <= a_addr_d;
            a_write_q    <= a_write_d;
            a_size_q     <= a_size_d;
            a_wdata_q    <= a_wdata_d;
            a_strb_q     <= a_strb_d;
            dvld_q       <= dvld_d;
            d_write_q    <= d_write_d;
            d_wdata_q    <= d_wdata_d;
            d_strb_q     <= d_strb_d;
            err_cancel_q <= err_cancel_d;
            htrans_q     <= htrans_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign ReqReady  = req_ready;
    assign RspValid  = rsp_valid_q;
    assign RspData   = rsp_data_q;
    assign RspErr    = rsp_err_q;
    assign HADDR     = a_addr_q;
    assign HWRITE    = a_write_q;
    assign HSIZE     = a_size_q;
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HTRANS    = htrans_q;
    assign HMASTLOCK = 1'b0;
    assign HWDATA    = d_wdata_q;
    assign HWSTRB    = d_strb_q;

endmodule

// File: tb/tb_ahb_lite_manager.sv
// Directed bench for ahb_lite_manager: single read, back-to-back writes, wait states,
// two-cycle ERROR with reissue, and reset during a data-phase wait.
module tb_ahb_lite_manager;

    logic        HCLK;
    logic        HRESETn;
    logic        ReqValid;
    logic        ReqReady;
    logic [33:0] ReqAddr;
    logic        ReqWrite;
    logic [2:0]  ReqSize;
    logic [63:0] ReqWData;
    logic [7:0]  ReqStrb;
    logic        RspValid;
    logic [63:0] RspData;
    logic        RspErr;
    logic [33:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic [63:0] HWDATA;
    logic [7:0]  HWSTRB;
    logic [63:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    int n_cmp = 0;
    int n_err = 0;

    ahb_lite_manager dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqAddr(ReqAddr), .ReqWrite(ReqWrite),
        .ReqSize(ReqSize), .ReqWData(ReqWData), .ReqStrb(ReqStrb),
        .RspValid(RspValid), .RspData(RspData), .RspErr(RspErr),
        .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HWSTRB(HWSTRB),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Step to just after the next rising edge; inputs are then driven for the new cycle
    task automatic next_cycle();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive_req(input logic [33:0] addr, input logic wr, input logic [63:0] wd,
                             input logic [7:0] strb);
        ReqValid = 1'b1;
        ReqAddr  = addr;
        ReqWrite = wr;
        ReqSize  = 3'b011;
        ReqWData = wd;
        ReqStrb  = strb;
    endtask

    task automatic drive_idle();
        ReqValid = 1'b0;
        ReqAddr  = '0;
        ReqWrite = 1'b0;
        ReqWData = '0;
        ReqStrb  = '0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (HTRANS !== 2'b00) begin n_err++; $display("FAIL rst_htrans: got %b exp 00", HTRANS); end
        n_cmp++; if (HADDR !== 34'h0) begin n_err++; $display("FAIL rst_haddr: got %h exp 0", HADDR); end
        n_cmp++; if (HWDATA !== 64'h0) begin n_err++; $display("FAIL rst_hwdata: got %h exp 0", HWDATA); end
        n_cmp++; if (RspValid !== 1'b0) begin n_err++; $display("FAIL rst_rspvalid: got %b exp 0", RspValid); end
        n_cmp++; if (ReqReady !== 1'b1) begin n_err++; $display("FAIL rst_reqready: got %b exp 1", ReqReady); end
        n_cmp++; if ({HBURST, HPROT, HMASTLOCK} !== {3'b000, 4'b0011, 1'b0}) begin
            n_err++; $display("FAIL rst_consts: got %b/%b/%b exp 000/0011/0", HBURST, HPROT, HMASTLOCK); end
    endtask

    task automatic test_single_read();
        drive_req(34'h0_8000_0010, 1'b0, 64'h0, 8'hFF); HREADY = 1'b1; #1;
        n_cmp++; if (ReqReady !== 1'b1) begin n_err++; $display("FAIL rd_reqready: got %b exp 1", ReqReady); end
        next_cycle(); drive_idle(); #1;
        n_cmp++; if (HTRANS !== 2'b10) begin n_err++; $display("FAIL rd_c1_htrans: got %b exp 10", HTRANS); end
        n_cmp++; if (HADDR !== 34'h0_8000_0010) begin n_err++; $display("FAIL rd_c1_haddr: got %h exp 080000010", HADDR); end
        n_cmp++; if (HWRITE !== 1'b0) begin n_err++; $display("FAIL rd_c1_hwrite: got %b exp 0", HWRITE); end
        next_cycle(); HRDATA = 64'hDEAD_BEEF; #1;
        n_cmp++; if (HTRANS !== 2'b00) begin n_err++; $display("FAIL rd_c2_htrans: got %b exp 00", HTRANS); end
        n_cmp++; if (RspValid !== 1'b0) begin n_err++; $display("FAIL rd_c2_rspvalid: got %b exp 0", RspValid); end
        next_cycle(); HRDATA = 64'h0; #1;
        n_cmp++; if (RspValid !== 1'b1) begin n_err++; $display("FAIL rd_c3_rspvalid: got %b exp 1", RspValid); end
        n_cmp++; if (RspData !== 64'hDEAD_BEEF) begin n_err++; $display("FAIL rd_c3_rspdata: got %h exp deadbeef", RspData); end
        n_cmp++; if (RspErr !== 1'b0) begin n_err++; $display("FAIL rd_c3_rsperr: got %b exp 0", RspErr); end
        next_cycle(); #1;
        n_cmp++; if (RspValid !== 1'b0) begin n_err++; $display("FAIL rd_c4_rspvalid: got %b exp 0", RspValid); end
    endtask

    task automatic test_back_to_back();
        logic [33:0] addr [3];
        logic [63:0] wd   [3];
        logic [7:0]  st   [3];
        addr = '{34'h1000, 34'h1008, 34'h1010};
        wd   = '{64'h1111_0000_0000_0001, 64'h2222_0000_0000_0002, 64'h3333_0000_0000_0003};
        st   = '{8'hFF, 8'h0F, 8'hF0};
        HREADY = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c < 3) drive_req(addr[c], 1'b1, wd[c], st[c]); else drive_idle();
            #1;
            if (c < 3) begin
                n_cmp++; if (ReqReady !== 1'b1) begin n_err++; $display("FAIL b2b_ready c%0d: got %b exp 1", c, ReqReady); end
            end
            if (c >= 1 && c <= 3) begin
                n_cmp++; if (HTRANS !== 2'b10 || HADDR !== addr[c-1] || HWRITE !== 1'b1) begin n_err++;
                    $display("FAIL b2b_addr c%0d: got %b/%h/%b exp 10/%h/1", c, HTRANS, HADDR, HWRITE, addr[c-1]); end
            end
            if (c >= 2 && c <= 4) begin
                n_cmp++; if (HWDATA !== wd[c-2] || HWSTRB !== st[c-2]) begin n_err++;
                    $display("FAIL b2b_wdata c%0d: got %h/%h exp %h/%h", c, HWDATA, HWSTRB, wd[c-2], st[c-2]); end
            end
            if (c == 4) begin
                n_cmp++; if (HTRANS !== 2'b00) begin n_err++; $display("FAIL b2b_idle: got %b exp 00", HTRANS); end
            end
            n_cmp++; if (RspValid !== (c >= 3 && c <= 5) || (RspValid && (RspData !== 64'h0 || RspErr !== 1'b0))) begin
                n_err++; $display("FAIL b2b_rsp c%0d: got v=%b d=%h e=%b exp v=%b d=0 e=0", c, RspValid, RspData, RspErr, (c >= 3 && c <= 5)); end
            next_cycle();
        end
    endtask

    task automatic test_wait_states();
        drive_req(34'h2000, 1'b0, 64'hA5A5_0000_0000_00A5, 8'h3C); HREADY = 1'b1;
        next_cycle(); drive_req(34'h2008, 1'b0, 64'h0, 8'hFF); #1;
        n_cmp++; if (ReqReady !== 1'b1) begin n_err++; $display("FAIL ws_accept2: got %b exp 1", ReqReady); end
        for (int c = 2; c <= 4; c++) begin
            next_cycle(); drive_idle();
            HREADY = (c == 4); HRDATA = (c == 4) ? 64'h0123_4567_89AB_CDEF : 64'h0; #1;
            n_cmp++; if (HTRANS !== 2'b10 || HADDR !== 34'h2008) begin n_err++;
                $display("FAIL ws_addr c%0d: got %b/%h exp 10/2008", c, HTRANS, HADDR); end
            n_cmp++; if (HWDATA !== 64'hA5A5_0000_0000_00A5 || HWSTRB !== 8'h3C) begin n_err++;
                $display("FAIL ws_wdata c%0d: got %h/%h exp a5a50000000000a5/3c", c, HWDATA, HWSTRB); end
            n_cmp++; if (ReqReady !== (c == 4) || RspValid !== 1'b0) begin n_err++;
                $display("FAIL ws_ready c%0d: got rdy=%b v=%b exp rdy=%b v=0", c, ReqReady, RspValid, (c == 4)); end
        end
        next_cycle(); HRDATA = 64'hFEED_0000_0000_2008; #1;
        n_cmp++; if (RspValid !== 1'b1 || RspData !== 64'h0123_4567_89AB_CDEF || HTRANS !== 2'b00) begin n_err++;
            $display("FAIL ws_rsp1: got v=%b d=%h t=%b exp 1/0123456789abcdef/00", RspValid, RspData, HTRANS); end
        next_cycle(); HRDATA = 64'h0; #1;
        n_cmp++; if (RspValid !== 1'b1 || RspData !== 64'hFEED_0000_0000_2008) begin n_err++;
            $display("FAIL ws_rsp2: got v=%b d=%h exp 1/feed000000002008", RspValid, RspData); end
        next_cycle();
    endtask

    task automatic test_error();
        drive_req(34'h3000, 1'b1, 64'hAAAA, 8'hFF); HREADY = 1'b1; HRESP = 1'b0;
        next_cycle(); drive_req(34'h3008, 1'b0, 64'h0, 8'hFF);
        next_cycle(); drive_idle(); HREADY = 1'b0; HRESP = 1'b1; #1;
        n_cmp++; if (HTRANS !== 2'b10 || HADDR !== 34'h3008) begin n_err++;
            $display("FAIL err_c2: got %b/%h exp 10/3008", HTRANS, HADDR); end
        next_cycle(); HREADY = 1'b1; HRESP = 1'b1; #1;
        n_cmp++; if (HTRANS !== 2'b00 || HADDR !== 34'h3008) begin n_err++;
            $display("FAIL err_c3_cancel: got %b/%h exp 00/3008", HTRANS, HADDR); end
        n_cmp++; if (ReqReady !== 1'b0 || RspValid !== 1'b0) begin n_err++;
            $display("FAIL err_c3_ready: got rdy=%b v=%b exp 0/0", ReqReady, RspValid); end
        next_cycle(); HRESP = 1'b0; #1;
        n_cmp++; if (RspValid !== 1'b1 || RspErr !== 1'b1 || RspData !== 64'h0) begin n_err++;
            $display("FAIL err_c4_rsp: got v=%b e=%b d=%h exp 1/1/0", RspValid, RspErr, RspData); end
        n_cmp++; if (HTRANS !== 2'b10 || HADDR !== 34'h3008 || HWRITE !== 1'b0) begin n_err++;
            $display("FAIL err_c4_reissue: got %b/%h/%b exp 10/3008/0", HTRANS, HADDR, HWRITE); end
        next_cycle(); HRDATA = 64'hBEEF_3008; #1;
        n_cmp++; if (HTRANS !== 2'b00 || RspValid !== 1'b0) begin n_err++;
            $display("FAIL err_c5: got t=%b v=%b exp 00/0", HTRANS, RspValid); end
        next_cycle(); HRDATA = 64'h0; #1;
        n_cmp++; if (RspValid !== 1'b1 || RspErr !== 1'b0 || RspData !== 64'hBEEF_3008) begin n_err++;
            $display("FAIL err_c6_rsp2: got v=%b e=%b d=%h exp 1/0/beef3008", RspValid, RspErr, RspData); end
        next_cycle();
    endtask

    task automatic test_reset_midop();
        drive_req(34'h4000, 1'b1, 64'h7777, 8'hFF); HREADY = 1'b1;
        next_cycle(); drive_idle();
        next_cycle(); HREADY = 1'b0; #1;
        n_cmp++; if (HWDATA !== 64'h7777) begin n_err++; $display("FAIL rm_pre: got %h exp 7777", HWDATA); end
        HRESETn = 1'b0; #1;
        n_cmp++; if (HTRANS !== 2'b00 || HADDR !== 34'h0 || HWDATA !== 64'h0 || HWRITE !== 1'b0 || HWSTRB !== 8'h0) begin
            n_err++; $display("FAIL rm_async: got %b/%h/%h/%b/%h exp all 0", HTRANS, HADDR, HWDATA, HWRITE, HWSTRB); end
        next_cycle(); HREADY = 1'b1;
        next_cycle(); HRESETn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            next_cycle(); #1;
            n_cmp++; if (RspValid !== 1'b0 || HTRANS !== 2'b00) begin n_err++;
                $display("FAIL rm_post c%0d: got v=%b t=%b exp 0/00", c, RspValid, HTRANS); end
        end
        drive_req(34'h4010, 1'b0, 64'h0, 8'hFF);
        next_cycle(); drive_idle(); #1;
        n_cmp++; if (HTRANS !== 2'b10 || HADDR !== 34'h4010) begin n_err++;
            $display("FAIL rm_new_addr: got %b/%h exp 10/4010", HTRANS, HADDR); end
        next_cycle(); HRDATA = 64'hC0FFEE;
        next_cycle(); HRDATA = 64'h0; #1;
        n_cmp++; if (RspValid !== 1'b1 || RspData !== 64'hC0FFEE || RspErr !== 1'b0) begin n_err++;
            $display("FAIL rm_new_rsp: got v=%b d=%h e=%b exp 1/c0ffee/0", RspValid, RspData, RspErr); end
    endtask

    initial begin
        HRESETn = 1'b0;
        HREADY  = 1'b1;
        HRESP   = 1'b0;
        HRDATA  = '0;
        ReqSize = 3'b011;
        drive_idle();
        test_reset();
        #20;
        next_cycle();
        HRESETn = 1'b1;
        next_cycle();
        test_single_read();
        next_cycle();
        test_back_to_back();
        test_wait_states();
        test_error();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
